// File: rtl/edge_bbox.sv
// edge_bbox: bounding box and edge-pixel count of a binary edge stream.
// Pixels arrive in raster order, one per pi_flag; edge when rx_data == 0.
// The frame result is reported with a one-cycle bbox_valid pulse.
// Optional feature macro: EDGE_BBOX_CNT_EN builds the edge counter, the
// edge_cnt output and the MIN_CNT threshold; without it found = seen.
module edge_bbox #(
    parameter int unsigned COL_NUM = 320,
    parameter int unsigned ROW_NUM = 720,
    parameter int unsigned MIN_CNT = 16
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        pi_flag,
    input  logic        sof,
    output logic [10:0] x_min,
    output logic [10:0] x_max,
    output logic [10:0] y_min,
    output logic [10:0] y_max,
    output logic [19:0] edge_cnt,
    output logic        found,
    output logic        bbox_valid
);

    localparam logic [0:0]  ST_ACCUM  = 1'b0;
    localparam logic [0:0]  ST_REPORT = 1'b1;
    localparam logic [10:0] COL_LAST  = 11'(COL_NUM - 1);
    localparam logic [10:0] ROW_LAST  = 11'(ROW_NUM - 1);

    logic [0:0]  state_q, state_d;
    logic [10:0] col_q, col_d, row_q, row_d;
    logic [10:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [10:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic        seen_q, seen_d;
    logic        restart;
    logic        is_edge;
    logic        found_d;
`ifdef EDGE_BBOX_CNT_EN
    logic [19:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_min_cnt;
    assign unused_min_cnt = 32'(MIN_CNT);
`endif

    // Next-state: a REPORT cycle or sof starts a fresh frame, and a pixel in
    // that same cycle lands at col 0 / row 0 of the cleared accumulators.
    always_comb begin
        restart = sof || (state_q == ST_REPORT);
        is_edge = pi_flag && (rx_data == 8'd0);
        state_d = ST_ACCUM;
        col_d   = restart ? 11'd0 : col_q;
        row_d   = restart ? 11'd0 : row_q;
        xmin_d  = restart ? '1 : xmin_q;
        xmax_d  = restart ? '0 : xmax_q;
        ymin_d  = restart ? '1 : ymin_q;
        ymax_d  = restart ? '0 : ymax_q;
        seen_d  = restart ? 1'b0 : seen_q;
`ifdef EDGE_BBOX_CNT_EN
        cnt_d   = restart ? 20'd0 : cnt_q;
`endif
        // Box update uses the pixel position before the counters advance.
        if (is_edge) begin
            if (col_d < xmin_d) xmin_d = col_d;
            if (col_d > xmax_d) xmax_d = col_d;
            if (row_d < ymin_d) ymin_d = row_d;
            if (row_d > ymax_d) ymax_d = row_d;
            seen_d = 1'b1;
`ifdef EDGE_BBOX_CNT_EN
            if (cnt_d != 20'hFFFFF) cnt_d = cnt_d + 20'd1;
`endif
        end
        if (pi_flag) begin
            if (col_d == COL_LAST) begin
                col_d = 11'd0;
                if (row_d == ROW_LAST) begin
                    row_d   = 11'd0;
                    state_d = ST_REPORT;
                end else begin
                    row_d = row_d + 11'd1;
                end
            end else begin
                col_d = col_d + 11'd1;
            end
        end
    end

    // Frame qualification from the accumulated state.
    always_comb begin
`ifdef EDGE_BBOX_CNT_EN
        found_d = seen_q && (cnt_q >= 20'(MIN_CNT));
`else
        found_d = seen_q;
`endif
    end

    // Counters, accumulators and FSM state.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            col_q   <= '0;
            row_q   <= '0;
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            seen_q  <= seen_d;
        end
    end

    // Result registers load only in the REPORT cycle and hold otherwise.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
            found      <= 1'b0;
            bbox_valid <= 1'b0;
        end else begin
            bbox_valid <= (state_q == ST_REPORT);
            if (state_q == ST_REPORT) begin
                x_min <= seen_q ? xmin_q : 11'd0;
                x_max <= seen_q ? xmax_q : 11'd0;
                y_min <= seen_q ? ymin_q : 11'd0;
                y_max <= seen_q ? ymax_q : 11'd0;
                found <= found_d;
            end
        end
    end

`ifdef EDGE_BBOX_CNT_EN
    // Saturating edge counter and its reported copy.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            edge_cnt <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == ST_REPORT) edge_cnt <= cnt_q;
        end
    end
`else
    assign edge_cnt = 20'd0;
`endif

endmodule

// File: tb/tb_edge_bbox.sv
// Testbench for edge_bbox on an 8x4 frame with MIN_CNT=2.
// Expected reports are pushed when a frame's last pixel is driven and
// popped by a monitor whenever bbox_valid is seen.
module tb_edge_bbox;

    localparam int unsigned COL_NUM = 8;
    localparam int unsigned ROW_NUM = 4;
    localparam int unsigned MIN_CNT = 2;

    typedef struct {
        logic [10:0] xmn;
        logic [10:0] xmx;
        logic [10:0] ymn;
        logic [10:0] ymx;
        logic [19:0] cnt;
        logic        fnd;
        int          cyc;
    } exp_t;

    logic        sclk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'hff;
    logic        pi_flag = 1'b0;
    logic        sof = 1'b0;
    logic [10:0] x_min, x_max, y_min, y_max;
    logic [19:0] edge_cnt;
    logic        found, bbox_valid;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [64:0] prev_out;
    logic        prev_ok = 1'b0;

    edge_bbox #(
        .COL_NUM (COL_NUM),
        .ROW_NUM (ROW_NUM),
        .MIN_CNT (MIN_CNT)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .rx_data    (rx_data),
        .pi_flag    (pi_flag),
        .sof        (sof),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .edge_cnt   (edge_cnt),
        .found      (found),
        .bbox_valid (bbox_valid)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // Reference result for a frame given as a bit map, bit index = y*8 + x.
    function automatic exp_t model(input logic [31:0] map);
        exp_t e;
        int   n;
        n     = 0;
        e.xmn = '1;
        e.xmx = '0;
        e.ymn = '1;
        e.ymx = '0;
        e.cyc = 0;
        for (int p = 0; p < 32; p++) begin
            if (map[p]) begin
                n++;
                if (11'(p % 8) < e.xmn) e.xmn = 11'(p % 8);
                if (11'(p % 8) > e.xmx) e.xmx = 11'(p % 8);
                if (11'(p / 8) < e.ymn) e.ymn = 11'(p / 8);
                if (11'(p / 8) > e.ymx) e.ymx = 11'(p / 8);
            end
        end
        if (n == 0) begin
            e.xmn = '0;
            e.ymn = '0;
        end
`ifdef EDGE_BBOX_CNT_EN
        e.cnt = 20'(n);
        e.fnd = (n >= 2);
`else
        e.cnt = 20'd0;
        e.fnd = (n > 0);
`endif
        return e;
    endfunction

    // Scoreboard monitor plus hold check between reports.
    always @(negedge sclk) begin
        if (rst) begin
            prev_ok = 1'b0;
        end else begin
            if (bbox_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_report: bbox_valid=1 at cycle %0d, none expected", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    n_checks++;
                    if (cyc !== mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL latency: cycle %0d expected %0d", cyc, mon_e.cyc);
                    end
                    n_checks++;
                    if (x_min !== mon_e.xmn) begin
                        n_fail++;
                        $display("FAIL x_min: got %0d expected %0d", x_min, mon_e.xmn);
                    end
                    n_checks++;
                    if (x_max !== mon_e.xmx) begin
                        n_fail++;
                        $display("FAIL x_max: got %0d expected %0d", x_max, mon_e.xmx);
                    end
                    n_checks++;
                    if (y_min !== mon_e.ymn) begin
                        n_fail++;
                        $display("FAIL y_min: got %0d expected %0d", y_min, mon_e.ymn);
                    end
                    n_checks++;
                    if (y_max !== mon_e.ymx) begin
                        n_fail++;
                        $display("FAIL y_max: got %0d expected %0d", y_max, mon_e.ymx);
                    end
                    n_checks++;
                    if (edge_cnt !== mon_e.cnt) begin
                        n_fail++;
                        $display("FAIL edge_cnt: got %0d expected %0d", edge_cnt, mon_e.cnt);
                    end
                    n_checks++;
                    if (found !== mon_e.fnd) begin
                        n_fail++;
                        $display("FAIL found: got %0b expected %0b", found, mon_e.fnd);
                    end
                end
            end else if (prev_ok) begin
                n_checks++;
                if ({x_min, x_max, y_min, y_max, edge_cnt, found} !== prev_out) begin
                    n_fail++;
                    $display("FAIL hold: outputs %h changed to %h without bbox_valid", prev_out,
                             {x_min, x_max, y_min, y_max, edge_cnt, found});
                end
            end
            prev_out = {x_min, x_max, y_min, y_max, edge_cnt, found};
            prev_ok  = 1'b1;
        end
    end

    task automatic idle(input int n, input logic s);
        repeat (n) begin
            @(posedge sclk);
            #1;
            pi_flag = 1'b0;
            sof     = s;
            rx_data = 8'hff;
        end
        if (s) begin
            @(posedge sclk);
            #1;
            sof = 1'b0;
        end
    endtask

    // Drive npix pixels of map; a full frame pushes its expected report.
    task automatic send_frame(input logic [31:0] map, input int npix, input bit gaps,
                              input bit sof_first);
        exp_t e;
        for (int p = 0; p < npix; p++) begin
            if (gaps) idle($urandom_range(0, 2), 1'b0);
            @(posedge sclk);
            #1;
            pi_flag = 1'b1;
            sof     = sof_first && (p == 0);
            rx_data = map[p] ? 8'd0 : 8'($urandom_range(1, 255));
            if (p == 31) begin
                e     = model(map);
                e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({x_min, x_max, y_min, y_max, edge_cnt, found, bbox_valid} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {x_min, x_max, y_min, y_max, edge_cnt, found, bbox_valid});
        end
        repeat (2) @(posedge sclk);
        #1 rst = 1'b0;
        idle(2, 1'b0);
    endtask

    task automatic test_basic();
        send_frame(32'h0008_2400, 32, 1'b0, 1'b0);  // (2,1) (5,1) (3,2)
        idle(4, 1'b0);
        send_frame(32'h0000_0000, 32, 1'b0, 1'b0);  // no edges
        idle(4, 1'b0);
        send_frame(32'h8000_0000, 32, 1'b0, 1'b0);  // (7,3) only, last pixel
        idle(4, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_frame(32'h0008_2400, 32, 1'b0, 1'b0);
        send_frame(32'h0000_0001, 32, 1'b0, 1'b0);  // (0,0) lands in REPORT cycle
        send_frame(32'h8000_0001, 32, 1'b0, 1'b1);  // sof with pixel in REPORT cycle
        idle(4, 1'b0);
    endtask

    task automatic test_sof();
        send_frame(32'h0000_1fff, 13, 1'b1, 1'b0);  // partial, discarded
        idle(1, 1'b1);
        send_frame(32'h4010_0000, 32, 1'b1, 1'b0);  // (4,2) (6,3)
        idle(4, 1'b0);
        send_frame(32'h0000_001f, 5, 1'b1, 1'b0);   // partial, then sof with pixel
        send_frame(32'h0000_0300, 32, 1'b1, 1'b1);  // (0,1) (1,1)
        idle(4, 1'b0);
    endtask

    task automatic test_rst_mid_frame();
        send_frame(32'h0000_03ff, 10, 1'b0, 1'b0);
        @(posedge sclk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({x_min, x_max, y_min, y_max, edge_cnt, found, bbox_valid} !== 66'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0",
                     {x_min, x_max, y_min, y_max, edge_cnt, found, bbox_valid});
        end
        pi_flag = 1'b0;
        repeat (2) @(posedge sclk);
        #1 rst = 1'b0;
        send_frame(32'h0420_0040, 32, 1'b0, 1'b0);  // (6,0) (5,2) (2,3)
        idle(4, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_sof();
        test_rst_mid_frame();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge sclk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reports outstanding, expected 0", sb.size());
        end
        idle(6, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
